// File: rtl/sm_reg_dump_tx.sv
// Register-dump UART transmitter: on start, sends header 0xA5 followed by every
// debug register (REG_COUNT words, MSB byte first) as 8N1 frames on tx.
module sm_reg_dump_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter int REG_COUNT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SEND} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
    localparam logic [4:0]  LAST_IDX  = 5'(REG_COUNT - 1);
    localparam logic [3:0]  STOP_BIT  = 4'd9;
    localparam logic [7:0]  HEADER    = 8'hA5;

    state_t      state;
    logic [4:0]  idx;
    logic [3:0]  bit_cnt;
    logic [15:0] baud_cnt;
    logic [7:0]  shift_byte;
    logic [31:0] word;
    logic [1:0]  byte_sel;
    logic        in_header;

    // Line level for bit n of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic bit_level(input logic [7:0] b, input logic [3:0] n);
        if (n == 4'd0)
            return 1'b0;
        else if (n >= STOP_BIT)
            return 1'b1;
        else
            return b[3'(n - 4'd1)];
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            regAddr    <= 5'd0;
            idx        <= 5'd0;
            bit_cnt    <= 4'd0;
            baud_cnt   <= 16'd0;
            shift_byte <= 8'd0;
            word       <= 32'd0;
            byte_sel   <= 2'd0;
            in_header  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_byte <= HEADER;
                        idx        <= 5'd0;
                        regAddr    <= 5'd0;
                        busy       <= 1'b1;
                        tx         <= 1'b0;
                        bit_cnt    <= 4'd0;
                        baud_cnt   <= 16'd0;
                        byte_sel   <= 2'd0;
                        in_header  <= 1'b1;
                        state      <= SEND;
                    end
                end
                // regAddr was already driven to idx on entry, so the core's
                // combinational regData is settled by the end of CAPTURE.
                FETCH: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    word       <= regData;
                    shift_byte <= regData[31:24];
                    byte_sel   <= 2'd0;
                    tx         <= 1'b0;
                    bit_cnt    <= 4'd0;
                    baud_cnt   <= 16'd0;
                    state      <= SEND;
                end
                SEND: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end else begin
                        baud_cnt <= 16'd0;
                        if (bit_cnt != STOP_BIT) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= bit_level(shift_byte, bit_cnt + 4'd1);
                        end else begin
                            bit_cnt <= 4'd0;
                            if (in_header) begin
                                in_header <= 1'b0;
                                regAddr   <= idx;
                                state     <= FETCH;
                            end else if (byte_sel != 2'd3) begin
                                byte_sel   <= byte_sel + 2'd1;
                                shift_byte <= word_byte(word, byte_sel + 2'd1);
                                tx         <= 1'b0;
                            end else if (idx != LAST_IDX) begin
                                idx     <= idx + 5'd1;
                                regAddr <= idx + 5'd1;
                                state   <= FETCH;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_reg_dump_tx.sv
// Bench for sm_reg_dump_tx: expected bytes are queued at each request and a
// UART-decoding monitor pops and compares them as frames arrive on tx.
module tb_sm_reg_dump_tx;

    localparam int C  = 4;
    localparam int RC = 2;
    localparam int BUSY_LEN = 10 * C * (1 + 4 * RC) + 2 * RC;   // 364

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data = 32'd0;
    logic        tx;
    logic        busy;

    logic [7:0] exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    bit  noise = 1'b0;
    bit  abort = 1'b0;
    int  cyc = 0;

    logic [7:0] mon_b;
    logic       mon_start;
    logic       mon_stop;
    logic [7:0] mon_exp;

    logic run_lvl;
    int   run_len = 0;

    always #5 clk = ~clk;

    sm_reg_dump_tx #(.CLK_PER_BIT(C), .REG_COUNT(RC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .regAddr (reg_addr),
        .regData (reg_data),
        .tx      (tx),
        .busy    (busy)
    );

    function automatic logic [31:0] model(input logic [4:0] a);
        logic [7:0] o;
        o = {3'b000, a};
        return {8'h10 + o, 8'h20 + o, 8'h30 + o, 8'h40 + o};
    endfunction

    // Cycle offset j (relative to the start edge) of the CAPTURE cycle of any word.
    function automatic bit is_capture(input int j);
        for (int i = 0; i < RC; i++)
            if (j == 10 * C * (1 + 4 * i) + 2 * i + 1) return 1'b1;
        return 1'b0;
    endfunction

    // Cycle counter: 0 in the cycle that follows the edge sampling start.
    initial forever begin
        @(posedge clk);
        if (start && !busy && rst_n) cyc = 0;
        else cyc = cyc + 1;
    end

    // Core model: combinational from regAddr, or garbage outside CAPTURE in noise mode.
    initial forever begin
        @(negedge clk);
        if (noise && !is_capture(cyc)) reg_data = $urandom;
        else reg_data = model(reg_addr);
    end

    // UART monitor / scoreboard consumer.
    initial forever begin
        @(negedge clk);
        if (abort) begin
            abort = 1'b0;
            continue;
        end
        if (rst_n && busy && tx == 1'b0) begin
            repeat (C / 2) @(negedge clk);
            mon_start = tx;
            for (int n = 0; n < 8; n++) begin
                repeat (C) @(negedge clk);
                mon_b[n] = tx;
            end
            repeat (C) @(negedge clk);
            mon_stop = tx;
            if (abort) begin
                abort = 1'b0;
                continue;
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL byte_unexpected: got %02h, none expected", mon_b);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_b !== mon_exp || mon_start !== 1'b0 || mon_stop !== 1'b1) begin
                    n_bad++;
                    $display("FAIL byte: got %02h start=%b stop=%b, expected %02h start=0 stop=1",
                             mon_b, mon_start, mon_stop, mon_exp);
                end
            end
        end
    end

    // Every tx level run inside a frame is a whole number of bit times,
    // except high runs that include the 2-cycle FETCH/CAPTURE gap.
    initial forever begin
        @(negedge clk);
        if (!rst_n || !busy) begin
            run_len = 0;
        end else if (run_len == 0) begin
            run_lvl = tx;
            run_len = 1;
        end else if (tx === run_lvl) begin
            run_len++;
        end else begin
            n_vec++;
            if (!(run_len % C == 0 || (run_lvl && run_len % C == 2))) begin
                n_bad++;
                $display("FAIL run_length: level %b lasted %0d cycles, expected multiple of %0d (or +2 for high)",
                         run_lvl, run_len, C);
            end
            run_lvl = tx;
            run_len = 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_frame();
        logic [31:0] w;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < RC; i++) begin
            w = model(5'(i));
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge just after the start edge; x1/x2 are cycles at which
    // extra start pulses are injected (-1 for none).
    task automatic wait_idle(input string name, input int x1, input int x2);
        int cnt = 0;
        while (busy && cnt < 5000) begin
            start = (cnt == x1 || cnt == x2);
            for (int i = 0; i < RC; i++) begin
                if (cyc == 10 * C * (1 + 4 * i) + 2 * i) begin
                    n_vec++;
                    if (reg_addr !== 5'(i)) begin
                        n_bad++;
                        $display("FAIL %s fetch_addr: got %0d, expected %0d", name, reg_addr, i);
                    end
                end
            end
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        n_vec++;
        if (cnt != BUSY_LEN) begin
            n_bad++;
            $display("FAIL %s busy_len: got %0d cycles, expected %0d", name, cnt, BUSY_LEN);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s bytes_missing: %0d left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        n_vec++;
        if (tx !== 1'b1 || busy !== 1'b0 || reg_addr !== 5'd0) begin
            n_bad++;
            $display("FAIL %s: tx=%b busy=%b regAddr=%0d, expected tx=1 busy=0 regAddr=0",
                     name, tx, busy, reg_addr);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_quiet("idle");
        end

        push_frame();
        pulse_start();
        wait_idle("basic", -1, -1);

        push_frame();
        pulse_start();
        wait_idle("start_while_busy", 20, 100);
        repeat (5) @(negedge clk);
        push_frame();
        pulse_start();
        wait_idle("fresh_after_busy", -1, -1);

        noise = 1'b1;
        push_frame();
        pulse_start();
        wait_idle("sampling_isolation", -1, -1);
        noise = 1'b0;

        // Abort during data bit 3 of byte 2 (0x10, bit value 0).
        push_frame();
        pulse_start();
        repeat (59) @(negedge clk);
        n_vec++;
        if (tx !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_reset_tx: got %b, expected 0", tx);
        end
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_quiet("held_reset");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check_quiet("after_reset_idle");
        push_frame();
        pulse_start();
        wait_idle("after_reset_frame", -1, -1);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_reg_dump_tx.md
# sm_reg_dump_tx

Register-dump transmitter for board-level debug. On request it walks the processor core's debug register port (regAddr → regData), snapshots each register, and streams the values out over a UART TX line. It is the consumer-side counterpart of the board tops that hard-wire one regAddr and show regData on LEDs: this block drives regAddr itself and carries regData off-chip. It sits in the board top beside sm_top, clocked from the same board clock.

## Interface
Parameters:
- CLK_PER_BIT, default 868: clock cycles per UART bit (868 gives 115200 baud at 100 MHz); legal range 2..65535.
- REG_COUNT, default 8: number of registers dumped, addresses 0..REG_COUNT-1; legal range 1..32.

Ports:
- clk  in  1  board clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  dump request; sampled only while idle.
- regAddr  out  5  debug register address to core.
- regData  in  32  debug register value from core; treated as combinational from regAddr.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from the start edge through the end of the last stop bit.

## Operation
- Reset values: tx=1, busy=0, regAddr=0, state IDLE, register index=0, bit counter=0, baud counter=0.
- Frame format: header byte 0xA5, then for each index 0..REG_COUNT-1 four bytes of the captured regData, MSB byte first. Each byte is 8N1: start bit (0), 8 data bits LSB first, stop bit (1).
- States: IDLE, FETCH, CAPTURE, SEND.
- IDLE: tx=1, busy=0. On a clock edge with start=1: load shift byte 0xA5, set index=0, busy=1, and enter SEND with the start bit already on tx.
- SEND: holds each bit for exactly CLK_PER_BIT cycles. When the stop bit of a byte finishes:
  - If this was the header, enter FETCH.
  - If this was byte 0, 1, or 2 of a word, load the next byte of the captured word and continue SEND with no gap.
  - If this was byte 3 and index<REG_COUNT-1, increment index and enter FETCH.
  - If this was byte 3 and index=REG_COUNT-1, enter IDLE and clear busy.
- FETCH: lasts one cycle; regAddr=index.
- CAPTURE: lasts one cycle; latch regData into the 32-bit word register, load its bits [31:24] as the shift byte, then enter SEND.
- regAddr holds its last driven value outside FETCH. It returns to 0 only at reset or at the next start.
- start is ignored while busy=1; there is no queuing. A start held high continuously re-triggers at the first IDLE cycle after busy falls.
- Reset asserted mid-frame aborts immediately: tx=1 and all state returns to reset values asynchronously. The partial byte is not completed.
- regData is sampled only in CAPTURE. Changes at any other time do not affect the byte in flight.

## Timing
- The start sampled at edge k gives busy=1 and tx=0 from edge k.
- Bit n of a byte occupies cycles [s + n·CLK_PER_BIT, s + (n+1)·CLK_PER_BIT), where s is the start-bit edge and n=0 is the start bit.
- Byte duration is 10·CLK_PER_BIT cycles. Back-to-back bytes within a word have no idle cycles.
- After the header and after each word except the last, there are exactly 2 cycles with tx=1 (FETCH, CAPTURE) before the next start bit.
- Total busy duration is 10·CLK_PER_BIT·(1+4·REG_COUNT) + 2·REG_COUNT cycles.
- busy falls on the edge that ends the final stop bit. The earliest re-triggering start is sampled on the next edge.

## Test plan
- Idle after reset: hold start=0 for 100 cycles → tx=1, busy=0, regAddr=0 throughout.
- Basic dump with CLK_PER_BIT=4, REG_COUNT=2, regData = {8'h10+addr, 8'h20+addr, 8'h30+addr, 8'h40+addr}, 1-cycle start pulse:
  - Decoded bytes: A5 10 20 30 40 11 21 31 41.
  - busy high for 10·4·9 + 4 = 364 cycles.
  - regAddr=0 then 1, each in the FETCH cycle.
- Bit timing with CLK_PER_BIT=7, REG_COUNT=1: every tx level run is a multiple of 7 cycles, except the 2-cycle high gaps. Header bits on tx are 0,1,0,1,0,0,1,0,1,1.
- Start while busy: pulse start mid-header and again mid-word → stream identical to a single request. After busy falls, a new start yields a fresh A5 frame.
- Sampling isolation: change regData every cycle except in CAPTURE → transmitted words equal the value present in the CAPTURE cycle only.
- Reset mid-frame: assert rst_n=0 during data bit 3 of the second byte → tx=1 and busy=0 immediately, with no clock edge needed. After release and a new start, a complete frame starting with A5 is sent.
